// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vec_mem_sequencer
//  Brief    : Serialises load/store vector and scalar instructions onto a
//             single element-wide data-memory port and reports completion
//             through mem_rdy so the control block can stall around it.
//  Revision : 1.0  initial release
// ============================================================================
module vec_mem_sequencer #(
  parameter int LANES   = 8,
  parameter int ELEM_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cl_mem_st,
  input  logic [1:0]                cl_mem_op,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LANES*ELEM_W-1:0]   vec_wdata,
  input  logic [ELEM_W-1:0]         esc_wdata,
  output logic                      mem_rdy,
  output logic                      busy,
  output logic [LANES*ELEM_W-1:0]   vec_rdata,
  output logic [ELEM_W-1:0]         esc_rdata,
  output logic [ADDR_W-1:0]         dmem_addr,
  output logic                      dmem_we,
  output logic [ELEM_W-1:0]         dmem_wdata,
  input  logic [ELEM_W-1:0]         dmem_rdata
);

  localparam int c_LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int c_WCNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t                    r_state;
  logic [c_LANE_W-1:0]       r_lane;
  logic [c_WCNT_W-1:0]       r_wcnt;
  logic                      r_scalar;
  logic [ADDR_W-1:0]         r_base;
  logic [LANES*ELEM_W-1:0]   r_vdata;
  logic [ELEM_W-1:0]         r_sdata;
  logic                      r_mem_rdy;
  logic                      r_busy;
  logic [LANES*ELEM_W-1:0]   r_vec_rdata;
  logic [ELEM_W-1:0]         r_esc_rdata;
  logic [ADDR_W-1:0]         r_dmem_addr;
  logic                      r_dmem_we;
  logic [ELEM_W-1:0]         r_dmem_wdata;

  logic                      w_last;
  logic [c_LANE_W-1:0]       w_lane_nxt;
  logic [ADDR_W-1:0]         w_addr_nxt;
  logic [ELEM_W-1:0]         w_wdata_nxt;

  // Next-element bookkeeping; scalar ops are a single element at lane 0,
  // and the address wraps modulo 2^ADDR_W by plain truncation.
  always_comb begin
    w_last      = r_scalar || (r_lane == c_LANE_W'(LANES - 1));
    w_lane_nxt  = r_lane + c_LANE_W'(1);
    w_addr_nxt  = r_base + ADDR_W'(w_lane_nxt);
    w_wdata_nxt = r_vdata[int'(w_lane_nxt)*ELEM_W +: ELEM_W];
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_wcnt       <= '0;
      r_scalar     <= 1'b0;
      r_base       <= '0;
      r_vdata      <= '0;
      r_sdata      <= '0;
      r_mem_rdy    <= 1'b1;
      r_busy       <= 1'b0;
      r_vec_rdata  <= '0;
      r_esc_rdata  <= '0;
      r_dmem_addr  <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cl_mem_st) begin
            r_scalar    <= cl_mem_op[0];
            r_base      <= base_addr;
            r_vdata     <= vec_wdata;
            r_sdata     <= esc_wdata;
            r_lane      <= '0;
            r_mem_rdy   <= 1'b0;
            r_busy      <= 1'b1;
            r_dmem_addr <= base_addr;
            if (cl_mem_op[1]) begin
              r_state <= ST_RD_ISSUE;
            end else begin
              // First store element goes out straight from the inputs since
              // the latches are being loaded on this same edge.
              r_state      <= ST_WR;
              r_dmem_we    <= 1'b1;
              r_dmem_wdata <= cl_mem_op[0] ? esc_wdata : vec_wdata[ELEM_W-1:0];
            end
          end
        end

        ST_RD_ISSUE: begin
          r_state <= ST_RD_WAIT;
          r_wcnt  <= c_WCNT_W'(MEM_LAT);
        end

        ST_RD_WAIT: begin
          if (r_wcnt == c_WCNT_W'(1)) begin
            r_wcnt <= '0;
            if (r_scalar) begin
              r_esc_rdata <= dmem_rdata;
            end else begin
              r_vec_rdata[int'(r_lane)*ELEM_W +: ELEM_W] <= dmem_rdata;
            end
            if (w_last) begin
              r_state   <= ST_DONE;
              r_mem_rdy <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_state     <= ST_RD_ISSUE;
              r_lane      <= w_lane_nxt;
              r_dmem_addr <= w_addr_nxt;
            end
          end else begin
            r_wcnt <= r_wcnt - c_WCNT_W'(1);
          end
        end

        ST_WR: begin
          if (w_last) begin
            r_state   <= ST_DONE;
            r_dmem_we <= 1'b0;
            r_mem_rdy <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_lane       <= w_lane_nxt;
            r_dmem_addr  <= w_addr_nxt;
            r_dmem_wdata <= w_wdata_nxt;
          end
        end

        // One cycle with cl_mem_st ignored so a held request cannot retrigger.
        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_dmem_we <= 1'b0;
          r_mem_rdy <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rdy    = r_mem_rdy;
  assign busy       = r_busy;
  assign vec_rdata  = r_vec_rdata;
  assign esc_rdata  = r_esc_rdata;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_we    = r_dmem_we;
  assign dmem_wdata = r_dmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_mem_sequencer
//  Brief    : Self-checking bench for vec_mem_sequencer with a byte-array
//             data memory and a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vec_mem_sequencer;

  localparam int LANES   = 8;
  localparam int ELEM_W  = 8;
  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cl_mem_st;
  logic [1:0]  cl_mem_op;
  logic [15:0] base_addr;
  logic [63:0] vec_wdata;
  logic [7:0]  esc_wdata;
  logic        mem_rdy;
  logic        busy;
  logic [63:0] vec_rdata;
  logic [7:0]  esc_rdata;
  logic [15:0] dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rd_pipe [MEM_LAT];
  logic [23:0] wr_q [$];
  logic [63:0] exp_vec;
  logic [7:0]  exp_esc;

  vec_mem_sequencer #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W),
    .ADDR_W (ADDR_W),
    .MEM_LAT(MEM_LAT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cl_mem_st (cl_mem_st),
    .cl_mem_op (cl_mem_op),
    .base_addr (base_addr),
    .vec_wdata (vec_wdata),
    .esc_wdata (esc_wdata),
    .mem_rdy   (mem_rdy),
    .busy      (busy),
    .vec_rdata (vec_rdata),
    .esc_rdata (esc_rdata),
    .dmem_addr (dmem_addr),
    .dmem_we   (dmem_we),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  assign dmem_rdata = rd_pipe[MEM_LAT-1];

  // Data memory: MEM_LAT-deep read pipeline plus a log of every write.
  always @(posedge clk) begin
    rd_pipe[0] <= mem[dmem_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (dmem_we) begin
      mem[dmem_addr] = dmem_wdata;
      wr_q.push_back({dmem_addr, dmem_wdata});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction: build the expected effect from the op rules, drive it,
  // and compare latency, write stream and read results.
  task automatic run_op(input logic [1:0] op, input logic [15:0] base,
                        input logic [63:0] vd, input logic [7:0] sd,
                        input bit noise, input bit hold);
    int          n;
    int          lat;
    int          k;
    logic [15:0] a;
    logic [23:0] exp_w [$];
    n   = op[0] ? 1 : LANES;
    lat = op[1] ? n * (1 + MEM_LAT) : n;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      if (op[1]) begin
        if (op[0]) exp_esc = mem[a];
        else       exp_vec[i*8 +: 8] = mem[a];
      end else begin
        exp_w.push_back({a, op[0] ? sd : vd[i*8 +: 8]});
      end
    end
    wr_q.delete();
    cl_mem_op = op; base_addr = base; vec_wdata = vd; esc_wdata = sd;
    cl_mem_st = 1'b1;
    @(posedge clk); #1;
    cl_mem_st = hold;
    k = 1;
    while (!mem_rdy && k <= lat + 20) begin
      check("busy_in_flight", {63'd0, busy}, 64'd1);
      if (noise) begin
        cl_mem_st = 1'($urandom);
        cl_mem_op = 2'($urandom);
        base_addr = 16'($urandom);
        vec_wdata = {$urandom, $urandom};
        esc_wdata = 8'($urandom);
      end
      @(posedge clk); #1;
      k++;
    end
    check("done_cycle", 64'(k), 64'(lat + 1));
    check("done_we", {63'd0, dmem_we}, 64'd0);
    check("done_busy", {63'd0, busy}, 64'd0);
    cl_mem_st = hold;
    @(posedge clk); #1;
    check("idle_no_retrigger", {63'd0, mem_rdy}, 64'd1);
    check("write_count", 64'(wr_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      check("write_addr_data", {40'd0, wr_q[i]}, {40'd0, exp_w[i]});
    check("vec_rdata", vec_rdata, exp_vec);
    check("esc_rdata", {56'd0, esc_rdata}, {56'd0, exp_esc});
  endtask

  // Reset asserted while lane 3 of a vector store is on the bus.
  task automatic reset_mid_store(input logic [15:0] base, input logic [63:0] vd);
    wr_q.delete();
    cl_mem_op = 2'b00; base_addr = base; vec_wdata = vd; cl_mem_st = 1'b1;
    @(posedge clk); #1;
    cl_mem_st = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("lane3_addr", {48'd0, dmem_addr}, {48'd0, base + 16'd3});
    check("lane3_we", {63'd0, dmem_we}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_vec = '0; exp_esc = '0;
    check("rst_we", {63'd0, dmem_we}, 64'd0);
    check("rst_rdy", {63'd0, mem_rdy}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_addr", {48'd0, dmem_addr}, 64'd0);
    repeat (6) begin @(posedge clk); #1; end
    check("rst_write_count", 64'(wr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++)
      check("rst_write", {40'd0, wr_q[i]}, {40'd0, base + 16'(i), vd[i*8 +: 8]});
  endtask

  initial begin
    logic [15:0] b;
    logic [1:0]  op;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0; cl_mem_st = 1'b0; cl_mem_op = 2'b00;
    base_addr = '0; vec_wdata = '0; esc_wdata = '0;
    exp_vec = '0; exp_esc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", {63'd0, mem_rdy}, 64'd1);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_we", {63'd0, dmem_we}, 64'd0);
    check("reset_addr", {48'd0, dmem_addr}, 64'd0);
    check("reset_wdata", {56'd0, dmem_wdata}, 64'd0);
    check("reset_vec", vec_rdata, 64'd0);
    check("reset_esc", {56'd0, esc_rdata}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    for (int i = 0; i < LANES; i++) mem[16'h0010 + i] = 8'hA0 + 8'(i);
    run_op(2'b10, 16'h0010, 64'd0, 8'd0, 1'b0, 1'b0);
    check("vload_const", vec_rdata, 64'hA7A6A5A4A3A2A1A0);
    run_op(2'b00, 16'h0020, 64'h0706050403020100, 8'd0, 1'b0, 1'b0);
    run_op(2'b00, 16'hFFFE, {$urandom, $urandom}, 8'd0, 1'b0, 1'b0);
    mem[16'h0005] = 8'h5A;
    run_op(2'b11, 16'h0005, 64'd0, 8'd0, 1'b0, 1'b0);
    check("sload_const", {56'd0, esc_rdata}, 64'h5A);
    check("sload_vec_kept", vec_rdata, 64'hA7A6A5A4A3A2A1A0);
    run_op(2'b01, 16'h0009, 64'd0, 8'h3C, 1'b0, 1'b0);
    check("sstore_mem", {56'd0, mem[16'h0009]}, 64'h3C);
    run_op(2'b00, 16'h0300, {$urandom, $urandom}, 8'd0, 1'b1, 1'b0);
    run_op(2'b00, 16'h0400, {$urandom, $urandom}, 8'd0, 1'b0, 1'b1);
    run_op(2'b11, 16'h0403, 64'd0, 8'd0, 1'b0, 1'b0);
    reset_mid_store(16'h0500, {$urandom, $urandom});
    run_op(2'b10, 16'h0500, 64'd0, 8'd0, 1'b0, 1'b0);

    // Randomized instruction stream.
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      b  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                       : 16'($urandom);
      run_op(op, b, {$urandom, $urandom}, 8'($urandom),
             1'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Executes the memory instructions issued by the processor control block: load vector, load scalar, store vector, store scalar.
- Each vector instruction is serialised into LANES element accesses on a single ELEM_W-wide data-memory port.
- Produces mem_rdy, which the control block uses to stall fetch/execute until the access completes.
- Sits between the control/register-file stage and the data memory.

Parameters:
- LANES, 8, elements per vector register.
- ELEM_W, 8, element and scalar width in bits.
- ADDR_W, 16, data-memory address width.
- MEM_LAT, 1, data-memory read latency in cycles (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cl_mem_st  in  1  start request (level).
- cl_mem_op  in  2  10=load vector, 11=load scalar, 00=store vector, 01=store scalar.
- base_addr  in  ADDR_W  element-0 / scalar address.
- vec_wdata  in  LANES*ELEM_W  store-vector data; lane i = bits [i*ELEM_W +: ELEM_W].
- esc_wdata  in  ELEM_W  store-scalar data.
- mem_rdy  out  1  1 = idle or done; 0 = operation in flight.
- busy  out  1  operation in flight (= ~mem_rdy).
- vec_rdata  out  LANES*ELEM_W  load-vector result.
- esc_rdata  out  ELEM_W  load-scalar result.
- dmem_addr  out  ADDR_W  memory address.
- dmem_we  out  1  memory write enable.
- dmem_wdata  out  ELEM_W  memory write data.
- dmem_rdata  in  ELEM_W  memory read data; valid MEM_LAT cycles after the address is presented.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; mem_rdy=1; busy=0; dmem_we=0; dmem_addr, dmem_wdata, vec_rdata, esc_rdata, lane counter and wait counter all 0.
- Reset wins over every other input and aborts any operation in flight. No further writes are issued and partially loaded lanes are cleared.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
- IDLE: a rising edge with cl_mem_st=1 accepts the operation. This edge is cycle 0.
  - On accept, op, base_addr, vec_wdata and esc_wdata are latched. Later changes to these inputs are ignored.
  - Loads go to RD_ISSUE and stores go to WR, with lane=0.
  - Element count is LANES for vector ops and 1 for scalar ops.
- RD_ISSUE (1 cycle): dmem_addr = base + lane, dmem_we=0. Go to RD_WAIT with the wait counter set to MEM_LAT.
- RD_WAIT (MEM_LAT cycles): on the last wait cycle, capture dmem_rdata.
  - Vector load: capture into vec_rdata lane `lane`.
  - Scalar load: capture into esc_rdata.
  - Then go to RD_ISSUE with lane+1, or to DONE after the last element.
- WR (1 cycle per element): dmem_we=1, dmem_addr = base + lane, dmem_wdata = latched lane data (or esc_wdata for scalar). Go to DONE after the last element.
  - A vector store holds dmem_we high for LANES consecutive cycles.
- DONE (1 cycle): mem_rdy=1, busy=0, dmem_we=0, then go to IDLE. cl_mem_st is ignored in DONE, so one instruction cannot trigger twice.
- mem_rdy=0 and busy=1 in RD_ISSUE, RD_WAIT and WR.
- cl_mem_st is ignored while busy.
- Latency from accept to DONE:
  - Vector load: LANES*(1+MEM_LAT) cycles after cycle 0.
  - Scalar load: 1+MEM_LAT cycles.
  - Vector store: LANES cycles.
  - Scalar store: 1 cycle.
- Address arithmetic is modulo 2^ADDR_W: base + lane wraps silently with no error.
- vec_rdata and esc_rdata hold their values until overwritten by a later load. Lanes not yet loaded keep their previous contents.
- dmem_addr holds its last value when idle.
- dmem_we is never 1 outside WR.

Test Plan:
- Load vector, MEM_LAT=1: mem[0x0010+i]=0xA0+i, base 0x0010, op 10 -> mem_rdy=0 during cycles 1..16, DONE with mem_rdy=1 in cycle 17, vec_rdata=0xA7A6A5A4A3A2A1A0, dmem_we never asserted.
- Store vector: vec_wdata=0x0706050403020100, base 0x0020, op 00 -> dmem_we=1 for 8 consecutive cycles, addresses 0x0020..0x0027, data 0x00..0x07, mem_rdy=1 in cycle 9.
- Wrap: store vector with base 0xFFFE -> addresses FFFE, FFFF, 0000..0005 in order.
- Scalar ops: load scalar with mem[0x0005]=0x5A -> esc_rdata=0x5A and DONE in cycle 3, vec_rdata unchanged. Then store scalar esc_wdata=0x3C at 0x0009 -> a single write, DONE in cycle 2.
- Busy / ignored inputs: toggle cl_mem_st, base_addr and vec_wdata during a vector store -> no new accept, latched values are still written. cl_mem_st held high through DONE -> the next accept occurs only from IDLE.
- Reset mid-op: rst_n=0 during lane 3 of a vector store -> next cycle IDLE, dmem_we=0, mem_rdy=1, no further writes. A subsequent load runs normally.
